// File: rtl/bnd_plse_pkg.sv
// Shared types and defaults for the BND_PLSE transmit framer.
package bnd_plse_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_MAX_PAYLOAD = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        ERR      = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SHORT = 2'd1,
        ERR_OVFL  = 2'd2,
        ERR_RETRY = 2'd3
    } err_e;

    // $clog2 that never yields a zero-width vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bnd_plse_tx_buf.sv
// Payload buffer: single-port RAM appended at the write pointer (== count),
// read combinationally by index while a frame is serialised.
module bnd_plse_tx_buf
    import bnd_plse_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_MAX_PAYLOAD,
    parameter int unsigned CW     = $clog2(DEPTH + 1),
    parameter int unsigned AW     = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data_c,
    output logic [CW-1:0]     count,
    output logic [CW-1:0]     count_nxt_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              wr_ok;

    // Writes are dropped once full, so the count saturates at DEPTH.
    assign wr_ok = wr_en && !clr && (count_q < CW'(DEPTH));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wr_ok) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[count_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data_c   = mem_q[rd_idx];
    assign count       = count_q;
    assign count_nxt_c = count_d;

endmodule

// File: rtl/bnd_plse_tx.sv
// BND_PLSE transmit framer: buffers a payload, serialises it with boundary
// markers on the first and last byte, then waits for ack with bounded retries.
module bnd_plse_tx
    import bnd_plse_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned MIN_PAYLOAD = 4,
    parameter int unsigned MAX_PAYLOAD = DEF_MAX_PAYLOAD,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              send,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              bnd_plse,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    input  logic              err_clr
);

    localparam int unsigned CW = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned AW = clog2_min1(MAX_PAYLOAD);
    localparam int unsigned TW = clog2_min1(ACK_TIMEOUT);
    localparam int unsigned RW = clog2_min1(MAX_RETRY + 1);

    // First and last byte must be distinct so a frame always has two markers.
    if (MIN_PAYLOAD < 2) begin : g_chk_min
        $error("bnd_plse_tx: MIN_PAYLOAD must be at least 2");
    end
    if (MAX_PAYLOAD < MIN_PAYLOAD) begin : g_chk_max
        $error("bnd_plse_tx: MAX_PAYLOAD must be at least MIN_PAYLOAD");
    end
    if (ACK_TIMEOUT < 1) begin : g_chk_tmo
        $error("bnd_plse_tx: ACK_TIMEOUT must be at least 1");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [RW-1:0]     retry_q, retry_d;
    err_e              err_q, err_d;

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              bnd_q, bnd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load_ready_q, load_ready_d;

    logic              buf_wr;
    logic              buf_clr;
    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     buf_count_nxt;
    logic [DATA_W-1:0] buf_rd_data;
    logic [CW-1:0]     frame_len;
    logic [CW-1:0]     last_idx;

    bnd_plse_tx_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_PAYLOAD),
        .CW     (CW),
        .AW     (AW)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (buf_wr),
        .wr_data     (load_data),
        .clr         (buf_clr),
        .rd_idx      (idx_d[AW-1:0]),
        .rd_data_c   (buf_rd_data),
        .count       (buf_count),
        .count_nxt_c (buf_count_nxt)
    );

    // A byte loaded in the same cycle as send belongs to the frame.
    assign buf_wr    = load_valid && load_ready_q;
    assign frame_len = buf_count + CW'(buf_wr);
    assign last_idx  = frame_len - CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            err_q        <= ERR_NONE;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            bnd_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            err_q        <= err_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            bnd_q        <= bnd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    // Next state, index/timer/retry bookkeeping and buffer control.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        retry_d = retry_q;
        err_d   = err_q;
        buf_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_valid && (buf_count == CW'(MAX_PAYLOAD))) begin
                    err_d   = ERR_OVFL;
                    state_d = ERR;
                end else if (send) begin
                    if (frame_len < CW'(MIN_PAYLOAD)) begin
                        err_d   = ERR_SHORT;
                        buf_clr = 1'b1;
                        state_d = ERR;
                    end else begin
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (idx_q == last_idx) begin
                    timer_d = '0;
                    state_d = WAIT_ACK;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    buf_clr = 1'b1;
                    retry_d = '0;
                    state_d = IDLE;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        idx_d   = '0;
                        state_d = SEND;
                    end else begin
                        err_d   = ERR_RETRY;
                        state_d = ERR;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ERR: begin
                if (err_clr) begin
                    err_d   = ERR_NONE;
                    buf_clr = 1'b1;
                    retry_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register inputs, decoded from the state being entered.
    always_comb begin
        data_out_d   = '0;
        data_valid_d = 1'b0;
        bnd_d        = 1'b0;
        busy_d       = (state_d == SEND) || (state_d == WAIT_ACK);
        done_d       = (state_q == WAIT_ACK) && ack;
        load_ready_d = (state_d == IDLE) && (buf_count_nxt < CW'(MAX_PAYLOAD))
                       && (err_d == ERR_NONE);
        if (state_d == SEND) begin
            data_out_d   = buf_rd_data;
            data_valid_d = 1'b1;
            bnd_d        = (idx_d == '0) || (idx_d == last_idx);
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign bnd_plse   = bnd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;
    assign err        = err_q;

endmodule

// File: doc/bnd_plse_tx.md
Name: bnd_plse_tx

Overview:
- Transmit-side framer for the BND_PLSE byte-stream protocol. It is the upstream driver that feeds dut_top's receive port.
- Software or a stimulus agent loads a payload into an internal buffer, then pulses send.
- The block serialises the payload one byte per cycle and marks the frame boundaries with BND_PLSE.
- It then waits for the receiver's ACK, retrying on timeout.

Parameters:
- DATA_W, 8, payload byte width.
- MIN_PAYLOAD, 4, smallest legal frame length in bytes.
- MAX_PAYLOAD, 64, largest legal frame length; equals the buffer depth.
- ACK_TIMEOUT, 16, cycles to wait for ack after the last byte.
- MAX_RETRY, 3, number of retransmissions before the error state.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  payload byte to append to the buffer.
- load_ready  out  1  buffer can accept a byte.
- send  in  1  single-cycle request to transmit the buffered payload.
- data_out  out  DATA_W  serial payload byte to the receiver.
- data_valid  out  1  data_out holds a frame byte.
- bnd_plse  out  1  frame boundary marker.
- ack  in  1  receiver acknowledge, a pulse of at least 1 cycle.
- busy  out  1  high from an accepted send until done or err.
- done  out  1  one-cycle pulse on a successful ack.
- err  out  2  sticky error code: 0 none, 1 short frame, 2 overflow, 3 retries exhausted.
- err_clr  in  1  clears err and returns the block to IDLE.

Behaviour:
- Reset state: all outputs 0 except load_ready=1. Buffer count = 0, retry count = 0, state = IDLE.
- Reset mid-frame aborts the frame immediately; no partial bnd_plse is produced after reset deasserts.
- Load:
  - Accepted when load_valid && load_ready.
  - load_ready = (state==IDLE) && (count<MAX_PAYLOAD) && (err==0).
  - load_valid while count==MAX_PAYLOAD sets err=2 and drops the byte; the buffer is unchanged.
- Send in IDLE:
  - count<MIN_PAYLOAD (including 0): err=1, buffer cleared, no bytes driven.
  - Otherwise go to SEND on the next cycle.
  - send while busy or while err!=0 is ignored.
- SEND:
  - Drives buffer[i] for i=0..count-1 on consecutive cycles with data_valid=1. There are no gaps.
  - Latency: the first byte appears on the cycle after send is sampled.
  - bnd_plse=1 on the first byte and on the last byte, 0 otherwise.
  - A frame therefore has exactly two bnd_plse cycles. Coincidence is not possible because MIN_PAYLOAD>=2.
  - The elaboration check must reject MIN_PAYLOAD<2.
- WAIT_ACK:
  - Entered on the cycle after the last byte; outputs idle (data_out=0).
  - A timer counts 0..ACK_TIMEOUT-1.
  - ack seen: done pulses on the next cycle, buffer cleared, retry count cleared, state IDLE.
  - Timer expiry with retry<MAX_RETRY: retry++, re-enter SEND and replay the same buffer from byte 0.
  - Timer expiry with retry==MAX_RETRY: err=3, state ERR.
  - ack on the same cycle as timer expiry counts as success.
  - ack during SEND or IDLE is ignored.
- ERR: busy=0, load_ready=0. err_clr clears err, buffer and retry, then goes to IDLE. err_clr in any other state is ignored.
- Indexing: the byte index and count are $clog2(MAX_PAYLOAD+1) bits. The timer is $clog2(ACK_TIMEOUT) bits. No wrap-around is permitted; the count saturates at MAX_PAYLOAD.
- State machine: IDLE -> SEND -> WAIT_ACK -> (IDLE | SEND | ERR); IDLE -> ERR on a short send or overflow; ERR -> IDLE on err_clr.

Decomposition:
- Shared package bnd_plse_pkg holds:
  - the state enum (IDLE, SEND, WAIT_ACK, ERR);
  - the err code enum (ERR_NONE, ERR_SHORT, ERR_OVFL, ERR_RETRY);
  - the DATA_W and MAX_PAYLOAD defaults.
- One natural sub-module, bnd_plse_tx_buf: a single-port payload RAM with a write pointer and count, read by index during SEND. The FSM, timer and retry logic stay in bnd_plse_tx.

Test Plan:
- Load 4 bytes 0xA0..0xA3, send -> four consecutive data_valid cycles with bytes A0,A1,A2,A3; bnd_plse high on A0 and A3 only; ack 3 cycles later -> done pulse, busy falls.
- Load 64 bytes (MAX), send, ack -> 64 bytes in order with no gaps; bnd_plse on bytes 0 and 63; load_ready=0 while sending.
- Load 64 bytes then one more load_valid -> byte dropped, err=2, load_ready=0; err_clr -> err=0, count=0, load_ready=1.
- Load 3 bytes, send -> no data_valid, err=1.
- Load 5 bytes, send, never ack -> four full frames (original plus 3 retries), each separated by 16 idle cycles; then err=3.
- Reset asserted on the 2nd byte of a 10-byte frame -> all outputs 0 immediately; after release, IDLE with count=0 and no bnd_plse.
